athos_ip_obi_slave: RTL and testbench

ATHOS_IP_OBI_SLAVE -- requirements
Module: athos_ip_obi_slave

---
 rtl/athos_ip_obi_slave.sv | 177 +++++++++++++++++
 tb/tb_athos_ip_obi_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/athos_ip_obi_slave.sv
// OBI slave window: coefficient SRAM pass-through plus CTRL/STATUS/LEN/IE accelerator registers.
// Single-cycle response; MEM accesses stall (gnt_o=0) while the job runs. IRQ logic under ATHOS_IP_IRQ_EN.
module athos_ip_obi_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0020_0000,
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] CTRL_OFF  = 32'h0010_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              start_o,
  output logic [MEM_AW:0]   len_o,
  input  logic              busy_i,
  input  logic              done_i,
  output logic              irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic [31:0]     MEM_BYTES = 32'(4) << MEM_AW;
  localparam logic [MEM_AW:0] LEN_MAX   = {1'b1, {MEM_AW{1'b0}}};

  state_e            state_q, state_d;
  logic [MEM_AW:0]   len_q, len_d;
  logic              rvalid_q, rvalid_d;
  logic              rsel_mem_q, rsel_mem_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              start_q, start_d;

  logic [31:0] offset;
  logic        in_win, sel_mem, sel_ctrl, sel_status, sel_len, sel_ie;
  logic        wr_acc, ctrl_start, status_clr, run_done;
  logic        irq_pend, ie_rd;
  logic [31:0] len_ext, len_wr;
  logic [MEM_AW:0] len_sat;

  assign offset     = addr_i - BASE_ADDR;
  assign in_win     = offset < WIN_SIZE;
  assign sel_mem    = in_win && (offset < MEM_BYTES);
  assign sel_ctrl   = in_win && !sel_mem && (offset == CTRL_OFF);
  assign sel_status = in_win && !sel_mem && (offset == CTRL_OFF + 32'h4);
  assign sel_len    = in_win && !sel_mem && (offset == CTRL_OFF + 32'h8);
  assign sel_ie     = in_win && !sel_mem && (offset == CTRL_OFF + 32'hC);

  // MEM is owned by the accelerator while a job runs, so the bus waits.
  assign gnt_o  = req_i && in_win && !rst_i && !(sel_mem && (state_q == ST_RUN));
  assign wr_acc = gnt_o && we_i;

  assign ctrl_start = wr_acc && sel_ctrl && be_i[0] && wdata_i[0];
  assign status_clr = wr_acc && sel_status && be_i[0] && wdata_i[1];
  assign run_done   = (state_q == ST_RUN) && done_i;

  assign mem_req_o   = gnt_o && sel_mem;
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_addr_o  = offset[MEM_AW+1:2];
  assign mem_wdata_o = wdata_i;

  always_comb begin
    len_ext = 32'(len_q);
    len_wr  = len_ext;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) len_wr[8*b +: 8] = wdata_i[8*b +: 8];
    end
    len_sat = (len_wr > 32'(LEN_MAX)) ? LEN_MAX : len_wr[MEM_AW:0];
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    start_d    = 1'b0;
    rvalid_d   = gnt_o;
    rsel_mem_d = gnt_o && sel_mem && !we_i;
    rdata_d    = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ctrl_start) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end else if (status_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_acc && sel_len && (state_q != ST_RUN)) len_d = len_sat;

    // Register read data is captured at grant; MEM data arrives from the SRAM next cycle.
    if (gnt_o && !we_i) begin
      if (sel_status)
        rdata_d = {29'b0, irq_pend, state_q == ST_DONE, (state_q == ST_RUN) || busy_i};
      else if (sel_len)
        rdata_d = len_ext;
      else if (sel_ie)
        rdata_d = {31'b0, ie_rd};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rvalid_q   <= 1'b0;
      rsel_mem_q <= 1'b0;
      rdata_q    <= 32'h0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rvalid_q   <= rvalid_d;
      rsel_mem_q <= rsel_mem_d;
      rdata_q    <= rdata_d;
      start_q    <= start_d;
    end
  end

`ifdef ATHOS_IP_IRQ_EN
  logic ie_q, ie_d, pend_q, pend_d;

  always_comb begin
    ie_d   = ie_q;
    pend_d = pend_q;
    if (status_clr) pend_d = 1'b0;
    if (run_done)   pend_d = 1'b1;
    if (wr_acc && sel_ie && be_i[0]) ie_d = wdata_i[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      pend_q <= pend_d;
    end
  end

  assign irq_pend = pend_q;
  assign ie_rd    = ie_q;
  assign irq_o    = pend_q && ie_q;
`else
  assign irq_pend = 1'b0;
  assign ie_rd    = 1'b0;
  assign irq_o    = 1'b0;
`endif

  assign rvalid_o = rvalid_q;
  assign rdata_o  = !rvalid_q ? 32'h0 : (rsel_mem_q ? mem_rdata_i : rdata_q);
  assign start_o  = start_q;
  assign len_o    = len_q;

endmodule

// File: tb/tb_athos_ip_obi_slave.sv
// Directed bench for athos_ip_obi_slave: queued expected read data checked by a negedge monitor.
module tb_athos_ip_obi_slave;

  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [31:0] WIN        = 32'h0020_0000;
  localparam logic [31:0] A_MEM      = BASE + 32'h10;
  localparam logic [31:0] A_CTRL     = BASE + 32'h0010_0000;
  localparam logic [31:0] A_STATUS   = A_CTRL + 32'h4;
  localparam logic [31:0] A_LEN      = A_CTRL + 32'h8;
  localparam logic [31:0] A_IE       = A_CTRL + 32'hC;
  localparam logic [31:0] A_VOID_TOP = BASE + WIN - 32'h4;
  localparam logic [31:0] A_VOID_MID = A_CTRL + 32'h10;
  localparam logic [31:0] A_OUT      = BASE - 32'h4;
`ifdef ATHOS_IP_IRQ_EN
  localparam logic [31:0] IRQ = 32'h1;
`else
  localparam logic [31:0] IRQ = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'hF;
  logic [31:0] wdata_i = '0;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;
  logic        gnt_o, rvalid_o, mem_req_o, mem_we_o, start_o, irq_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  mem_be_o;
  logic [9:0]  mem_addr_o;
  logic [10:0] len_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tb_mem [0:1023];
  logic        obs_mem_req, obs_mem_we;
  logic [9:0]  obs_mem_addr;

  athos_ip_obi_slave #(
    .BASE_ADDR(BASE), .WIN_SIZE(WIN), .MEM_AW(10), .CTRL_OFF(32'h0010_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .start_o(start_o), .len_o(len_o),
    .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Coefficient SRAM model: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) tb_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      mem_rdata_i <= tb_mem[mem_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected rvalid", 32'(rvalid_o), 32'h0);
      end else begin
        check("rdata", rdata_o, exp_q.pop_front());
      end
    end else begin
      check("rdata idle zero", rdata_o, 32'h0);
    end
  end

  // Called just after a rising edge; presents one request for one cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, input logic exp_gnt, input logic [31:0] exp_rd,
                      input string name);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    #1;
    check({name, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
    obs_mem_req = mem_req_o; obs_mem_we = mem_we_o; obs_mem_addr = mem_addr_o;
    if (exp_gnt) exp_q.push_back(w ? 32'h0 : exp_rd);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    req_i = 1'b1; addr_i = A_MEM;
    idle(2);
    #1;
    check("gnt in reset", 32'(gnt_o), 32'h0);
    check("mem_req in reset", 32'(mem_req_o), 32'h0);
    check("rvalid in reset", 32'(rvalid_o), 32'h0);
    check("start in reset", 32'(start_o), 32'h0);
    rst_i = 1'b0; req_i = 1'b0;
    idle(1);
    check("irq after reset", 32'(irq_o), 32'h0);
    check("len after reset", 32'(len_o), 32'h0);

    xfer(A_MEM, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, "mem wr");
    check("mem_req on wr", 32'(obs_mem_req), 32'h1);
    check("mem_addr on wr", 32'(obs_mem_addr), 32'h4);
    check("mem_we on wr", 32'(obs_mem_we), 32'h1);
    xfer(A_MEM, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, "mem rd");
    xfer(A_MEM + 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, "mem wr2");
    xfer(A_MEM + 32'h4, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 32'h0, "mem wr be");
    check("mem_addr wr be", 32'(obs_mem_addr), 32'h5);
    xfer(A_MEM + 32'h4, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFF_5678, "mem rd be");

    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "status idle");
    busy_i = 1'b1;
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1, "status busy");
    busy_i = 1'b0;
    done_i = 1'b1; idle(1); done_i = 1'b0;
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "done in idle");

    xfer(A_LEN, 1'b1, 4'hF, 32'h0000_07FF, 1'b1, 32'h0, "len wr sat");
    xfer(A_LEN, 1'b0, 4'hF, 32'h0, 1'b1, 32'h400, "len rd sat");
    xfer(A_LEN, 1'b1, 4'h2, 32'h0000_0100, 1'b1, 32'h0, "len wr be");
    xfer(A_LEN, 1'b0, 4'hF, 32'h0, 1'b1, 32'h100, "len rd be");
    xfer(A_LEN, 1'b1, 4'hF, 32'h0000_0020, 1'b1, 32'h0, "len wr");
    xfer(A_LEN, 1'b0, 4'hF, 32'h0, 1'b1, 32'h20, "len rd");
    xfer(A_IE, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, "ie wr");
    xfer(A_IE, 1'b0, 4'hF, 32'h0, 1'b1, IRQ, "ie rd");

    xfer(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, "ctrl start");
    check("start pulse", 32'(start_o), 32'h1);
    xfer(A_CTRL, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "ctrl rd");
    check("start one cycle", 32'(start_o), 32'h0);
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1, "status run");
    xfer(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, "ctrl in run");
    check("no start in run", 32'(start_o), 32'h0);
    xfer(A_LEN, 1'b1, 4'hF, 32'h55, 1'b1, 32'h0, "len wr run");
    xfer(A_LEN, 1'b0, 4'hF, 32'h0, 1'b1, 32'h20, "len kept run");

    req_i = 1'b1; addr_i = A_MEM; we_i = 1'b0; be_i = 4'hF;
    #1; check("mem stall 0", 32'(gnt_o), 32'h0);
    repeat (2) begin @(posedge clk); #1; check("mem stall", 32'(gnt_o), 32'h0); end
    done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    #1; check("mem gnt after done", 32'(gnt_o), 32'h1);
    exp_q.push_back(32'hCAFE_F00D);
    @(posedge clk); #1; req_i = 1'b0;
    check("irq after done", 32'(irq_o), IRQ);
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h2 | (IRQ << 2), "status done");
    xfer(A_STATUS, 1'b1, 4'hF, 32'h2, 1'b1, 32'h0, "status w1c");
    check("irq cleared", 32'(irq_o), 32'h0);
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "status cleared");

    xfer(A_VOID_TOP, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "void top rd");
    xfer(A_VOID_MID, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, "void wr");
    xfer(A_VOID_MID, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "void rd");
    xfer(A_OUT, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, "out of window");

    xfer(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, "ctrl start2");
    check("start pulse2", 32'(start_o), 32'h1);
    done_i = 1'b1; idle(1); done_i = 1'b0;
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h2 | (IRQ << 2), "status done2");
    xfer(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, "ctrl restart");
    check("restart pulse", 32'(start_o), 32'h1);
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1 | (IRQ << 2), "status rerun");

    req_i = 1'b1; addr_i = A_MEM; we_i = 1'b0;
    #1; check("pending rd stalled", 32'(gnt_o), 32'h0);
    rst_i = 1'b1;
    #1; check("gnt under reset", 32'(gnt_o), 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0; req_i = 1'b0;
    check("rvalid after reset", 32'(rvalid_o), 32'h0);
    check("start after reset", 32'(start_o), 32'h0);
    xfer(A_STATUS, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "status after rst");
    xfer(A_LEN, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "len after rst");
    xfer(A_IE, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, "ie after rst");
    check("irq after rst", 32'(irq_o), 32'h0);

    idle(2);
    check("responses drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
